// File: rtl/uart_rx_packet_parser.sv
// Frames UART bytes as SYNC/LEN/payload/CHECKSUM packets and replays good payloads on a valid/ready stream.
// Latency: first payload byte is presented the cycle after the checksum byte is accepted.
// Backpressure: i_ready low holds o_data/o_last/o_valid; bytes arriving while replaying are dropped with o_overrun.
module uart_rx_packet_parser #(
    parameter int          CLOCK_FREQUENCY = 50000000,
    parameter int          BAUD            = 115200,
    parameter int          MAX_LEN         = 16,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
    parameter int          TIMEOUT_CYCLES  = 20 * (CLOCK_FREQUENCY / BAUD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Rx_valid,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic       o_pkt_done,
    output logic       o_err_csum,
    output logic       o_err_len,
    output logic       o_err_timeout,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int IW    = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] IDX_ONE   = 1;
    localparam logic [TW-1:0] TMO_ONE   = 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_SEND
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_csum_q, err_csum_d;
    logic            err_len_q, err_len_d;
    logic            err_tmo_q, err_tmo_d;
    logic            overrun_q, overrun_d;
    logic            pkt_done_q, pkt_done_d;
    logic            wr_en;
    logic [7:0]      pbuf_q [DEPTH];

    logic            at_last;
    logic            expired;

    // Index points at the final payload byte; drives both the PAYLOAD exit and o_last.
    assign at_last = (idx_q == (len_q - IDX_ONE));
    // Idle budget between bytes is used up; a byte arriving this same cycle still takes priority.
    assign expired = (tmo_q == TMO_LAST);

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            len_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            err_csum_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            overrun_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            err_csum_q <= err_csum_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            overrun_q  <= overrun_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // Payload storage; contents are only observed in SEND so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pbuf_q[idx_q[AW-1:0]] <= i_Rx_Byte;
        end
    end

    // Next-state logic: packet framing, checksum accumulation, timeout and replay handshakes.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        tmo_d      = '0;
        err_csum_d = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        overrun_d  = 1'b0;
        pkt_done_d = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (i_Rx_valid && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (i_Rx_valid) begin
                    if ((i_Rx_Byte == 8'h00) || (i_Rx_Byte > MAX_LEN_B)) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else begin
                        len_d   = IW'(i_Rx_Byte);
                        csum_d  = i_Rx_Byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end else if (expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            S_PAYLOAD: begin
                if (i_Rx_valid) begin
                    wr_en  = 1'b1;
                    csum_d = csum_q + i_Rx_Byte;
                    idx_d  = idx_q + IDX_ONE;
                    if (at_last) begin
                        state_d = S_CSUM;
                    end
                end else if (expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            S_CSUM: begin
                if (i_Rx_valid) begin
                    if (i_Rx_Byte == csum_q) begin
                        idx_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = S_HUNT;
                    end
                end else if (expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            S_SEND: begin
                // The buffer is single-packet, so anything arriving now (even SYNC) is lost.
                if (i_Rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (i_ready) begin
                    if (at_last) begin
                        pkt_done_d = 1'b1;
                        idx_d      = '0;
                        state_d    = S_HUNT;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    assign o_valid       = (state_q == S_SEND);
    assign o_data        = o_valid ? pbuf_q[idx_q[AW-1:0]] : 8'h00;
    assign o_last        = o_valid && at_last;
    assign o_busy        = (state_q != S_HUNT);
    assign o_pkt_done    = pkt_done_q;
    assign o_err_csum    = err_csum_q;
    assign o_err_len     = err_len_q;
    assign o_err_timeout = err_tmo_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Scoreboard bench for uart_rx_packet_parser: directed packets, expected bytes/pulses queued at issue time.
// A negedge monitor compares every presented output byte and every status pulse against the queues.
// Stimulus changes 1ns after the rising edge.
module tb_uart_rx_packet_parser;

    localparam int T = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_Rx_Byte;
    logic       i_Rx_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;
    logic       o_pkt_done;
    logic       o_err_csum;
    logic       o_err_len;
    logic       o_err_timeout;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    // Expected payload stream: {last, data}
    logic [8:0] qdata [$];
    // Expected pulse counts: 0 done, 1 csum, 2 len, 3 timeout, 4 overrun
    int exp_cnt [5];
    logic done_due = 1'b0;

    uart_rx_packet_parser #(
        .CLOCK_FREQUENCY(50000000),
        .BAUD(115200),
        .MAX_LEN(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_Rx_Byte(i_Rx_Byte),
        .i_Rx_valid(i_Rx_valid),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_last(o_last),
        .o_pkt_done(o_pkt_done),
        .o_err_csum(o_err_csum),
        .o_err_len(o_err_len),
        .o_err_timeout(o_err_timeout),
        .o_overrun(o_overrun),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        i_Rx_Byte  = b;
        i_Rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_Rx_valid = 1'b0;
        i_Rx_Byte  = 8'h00;
    endtask

    task automatic push_exp(input int n, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0] a [3];
        a[0] = a0;
        a[1] = a1;
        a[2] = a2;
        for (int i = 0; i < n; i++) begin
            qdata.push_back({(i == n - 1), a[i]});
        end
        exp_cnt[0]++;
    endtask

    task automatic check_idle(input string name);
        chk(name, {o_data, o_valid, o_last, o_pkt_done, o_err_csum, o_err_len,
                   o_err_timeout, o_overrun, o_busy}, 32'h0);
    endtask

    task automatic drained(input string name);
        chk({name, "_stream_left"}, qdata.size(), 0);
        chk({name, "_pulses_left"}, exp_cnt[0] + exp_cnt[1] + exp_cnt[2] + exp_cnt[3] + exp_cnt[4], 0);
        chk({name, "_busy"}, o_busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qdata.delete();
        for (int k = 0; k < 5; k++) exp_cnt[k] = 0;
        done_due = 1'b0;
    endtask

    // Monitor: compares presented bytes and pulses against the scoreboard.
    always @(negedge clk) begin
        logic [4:0] pulses;
        if (done_due) begin
            chk("done_timing", o_pkt_done, 1'b1);
            chk("valid_drop", o_valid, 1'b0);
            done_due = 1'b0;
        end
        if (o_valid === 1'b1) begin
            if (qdata.size() == 0) begin
                chk("unexpected_valid", o_valid, 1'b0);
            end else begin
                chk("data", o_data, qdata[0][7:0]);
                chk("last", o_last, qdata[0][8]);
                if (i_ready) begin
                    if (qdata[0][8]) done_due = 1'b1;
                    void'(qdata.pop_front());
                end
            end
        end
        pulses = {o_overrun, o_err_timeout, o_err_len, o_err_csum, o_pkt_done};
        for (int k = 0; k < 5; k++) begin
            if (pulses[k] === 1'b1) begin
                checks++;
                if (exp_cnt[k] == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse kind=%0d actual=1 expected=0", k);
                end else begin
                    exp_cnt[k]--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) exp_cnt[k] = 0;
        rst        = 1'b1;
        i_ready    = 1'b1;
        i_Rx_valid = 1'b0;
        i_Rx_Byte  = 8'h00;
        idle(3);
        check_idle("reset");
        rst = 1'b0;
        idle(2);

        // Good packet with leading noise
        push_exp(3, 8'h11, 8'h22, 8'h33);
        rx_byte(8'h00); rx_byte(8'hFF); rx_byte(8'hA5); rx_byte(8'h03);
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h69);
        chk("latency1_valid", o_valid, 1'b1);
        idle(6);
        drained("good");

        // Bad checksum, then a 1-byte good packet
        exp_cnt[1]++;
        rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h6A);
        chk("badcsum_no_valid", o_valid, 1'b0);
        idle(3);
        drained("badcsum");
        push_exp(1, 8'h7E, 8'h00, 8'h00);
        rx_byte(8'hA5); rx_byte(8'h01); rx_byte(8'h7E); rx_byte(8'h7F);
        idle(4);
        drained("one_byte");

        // Illegal lengths
        exp_cnt[2]++;
        rx_byte(8'hA5); rx_byte(8'h00);
        idle(2);
        drained("len_zero");
        exp_cnt[2]++;
        rx_byte(8'hA5); rx_byte(8'h11);
        idle(2);
        drained("len_17");

        // Backpressure on byte 22, SYNC byte strobed during SEND
        push_exp(3, 8'h11, 8'h22, 8'h33);
        rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h69);
        idle(1);
        i_ready = 1'b0;
        exp_cnt[4]++;
        rx_byte(8'hA5);
        idle(4);
        chk("stall_held", {o_valid, o_data}, {1'b1, 8'h22});
        i_ready = 1'b1;
        idle(5);
        drained("backpressure");

        // Inter-byte timeout
        exp_cnt[3]++;
        rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11);
        idle(T);
        idle(3);
        drained("timeout");

        // Bytes landing exactly on the expiry cycle are accepted
        push_exp(3, 8'h11, 8'h22, 8'h33);
        rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11);
        idle(T - 1);
        rx_byte(8'h22);
        idle(T - 1);
        rx_byte(8'h33);
        idle(T - 1);
        rx_byte(8'h69);
        idle(6);
        drained("expiry_edge");

        // Reset mid-PAYLOAD
        rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11);
        do_reset();
        check_idle("rst_payload");

        // Reset mid-SEND
        i_ready = 1'b0;
        push_exp(3, 8'h11, 8'h22, 8'h33);
        rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h69);
        idle(2);
        chk("pre_rst_send", {o_valid, o_data}, {1'b1, 8'h11});
        do_reset();
        check_idle("rst_send");
        i_ready = 1'b1;
        idle(2);

        // Recovery packet
        push_exp(2, 8'h01, 8'hA5, 8'h00);
        rx_byte(8'hA5); rx_byte(8'h02); rx_byte(8'h01); rx_byte(8'hA5); rx_byte(8'hA8);
        idle(6);
        drained("recovery");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
